// File: rtl/demux_deser8.sv
// Serial-to-parallel demux receiver: bit k of a frame lands in bit k of the word; optional DEMUX_DESER8_PARITY_EN adds an even-parity bit per frame.
// Latency: dout_valid rises 1 cycle after the last bit of a frame (the parity bit when parity is enabled).
// Backpressure: a word completing while dout is held and not drained is dropped and sets sticky overrun.
module demux_deser8 #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
`ifdef DEMUX_DESER8_PARITY_EN
    output logic [IDX_W:0]   idx,
    output logic             parity_err,
`else
    output logic [IDX_W-1:0] idx,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
);

`ifdef DEMUX_DESER8_PARITY_EN
    localparam int IW = IDX_W + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH);
`else
    localparam int IW = IDX_W;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
`endif

    logic [WIDTH-1:0] assembly;
    logic [IW-1:0]    eff_idx;
    logic [WIDTH-1:0] word;
    logic             word_good;
    logic             complete;
    logic             can_load;

    always_comb begin
        eff_idx   = sync ? '0 : idx;
        complete  = din_valid && (eff_idx == LAST_IDX);
        can_load  = !dout_valid || dout_ready;
        word      = assembly;
`ifdef DEMUX_DESER8_PARITY_EN
        // The last bit is parity; data bits plus parity must hold an even number of ones.
        word_good = ~(^assembly ^ din);
`else
        word[WIDTH-1] = din;
        word_good     = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            assembly   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef DEMUX_DESER8_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (din_valid) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (eff_idx == IW'(i)) begin
                        assembly[i] <= din;
                    end
                end
                idx <= (eff_idx == LAST_IDX) ? '0 : eff_idx + IW'(1);
            end else if (sync) begin
                idx <= '0;
            end

            // A fresh word may replace one being drained in the same cycle.
            if (complete && word_good && can_load) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (complete && word_good && !can_load) begin
                overrun <= 1'b1;
            end

`ifdef DEMUX_DESER8_PARITY_EN
            parity_err <= complete && !word_good;
`endif
        end
    end

endmodule

// File: tb/tb_demux_deser8.sv
// Directed bench for demux_deser8: reset, single frame, back-to-back/overrun, resync, async reset, optional parity.
module tb_demux_deser8;

`ifdef DEMUX_DESER8_PARITY_EN
    localparam int IW = 4;
`else
    localparam int IW = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic          sync = 1'b0;
    logic [IW-1:0] idx;
    logic [7:0]    dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          overrun;
`ifdef DEMUX_DESER8_PARITY_EN
    logic          parity_err;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    demux_deser8 #(.WIDTH(8), .IDX_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .idx        (idx),
`ifdef DEMUX_DESER8_PARITY_EN
        .parity_err (parity_err),
`endif
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun)
    );

    // One clock: inputs applied here, outputs observed 1 ns after the edge.
    task automatic cyc(input logic b, input logic v, input logic s, input logic r);
        din        = b;
        din_valid  = v;
        sync       = s;
        dout_ready = r;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        sync       = 1'b0;
        dout_ready = 1'b0;
    endtask

    // Sends a full frame; in parity builds an even-parity bit (optionally flipped) follows.
    task automatic send_frame(input logic [7:0] w, input logic s0, input logic r_last, input logic pflip);
`ifdef DEMUX_DESER8_PARITY_EN
        for (int i = 0; i < 8; i++) cyc(w[i], 1'b1, s0 && (i == 0), 1'b0);
        cyc((^w) ^ pflip, 1'b1, 1'b0, r_last);
`else
        for (int i = 0; i < 8; i++) cyc(w[i], 1'b1, s0 && (i == 0), (i == 7) ? r_last : 1'b0);
        if (pflip) $display("note: parity flip ignored without parity");
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (idx !== '0) $display("FAIL reset_idx got %0d want 0", idx); else passed++;
        total++; if (dout !== 8'h00) $display("FAIL reset_dout got %h want 00", dout); else passed++;
        total++; if (dout_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", dout_valid); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
        rst_n = 1'b1;
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (idx !== '0 || dout_valid !== 1'b0) $display("FAIL idle_state got idx=%0d vld=%b want 0/0", idx, dout_valid); else passed++;
    endtask

    task automatic test_single_frame();
        // bits 1,0,1,1,0,0,1,0 LSB first -> 0x4D
        send_frame(8'h4D, 1'b1, 1'b0, 1'b0);
        total++; if (dout_valid !== 1'b1) $display("FAIL single_valid got %b want 1", dout_valid); else passed++;
        total++; if (dout !== 8'h4D) $display("FAIL single_dout got %h want 4d", dout); else passed++;
        total++; if (idx !== '0) $display("FAIL single_idx got %0d want 0", idx); else passed++;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            total++; if (dout !== 8'h4D || dout_valid !== 1'b1) $display("FAIL single_hold%0d got %h/%b want 4d/1", k, dout, dout_valid); else passed++;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (dout_valid !== 1'b0 || dout !== 8'h4D) $display("FAIL single_drain got %h/%b want 4d/0", dout, dout_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        total++; if (dout !== 8'hA5 || dout_valid !== 1'b1) $display("FAIL b2b_first got %h/%b want a5/1", dout, dout_valid); else passed++;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        total++; if (dout !== 8'hA5) $display("FAIL b2b_stall_dout got %h want a5", dout); else passed++;
        total++; if (overrun !== 1'b1) $display("FAIL b2b_overrun got %b want 1", overrun); else passed++;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (overrun !== 1'b1) $display("FAIL overrun_sticky got %b want 1", overrun); else passed++;
        do_reset();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        total++; if (dout !== 8'h3C || dout_valid !== 1'b1) $display("FAIL b2b_drain_dout got %h/%b want 3c/1", dout, dout_valid); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL b2b_drain_overrun got %b want 0", overrun); else passed++;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (dout_valid !== 1'b0) $display("FAIL b2b_final_drain got %b want 0", dout_valid); else passed++;
    endtask

    task automatic test_resync();
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (idx !== IW'(3) || dout_valid !== 1'b0) $display("FAIL resync_partial got idx=%0d vld=%b want 3/0", idx, dout_valid); else passed++;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        total++; if (dout !== 8'h81 || dout_valid !== 1'b1) $display("FAIL resync_dout got %h/%b want 81/1", dout, dout_valid); else passed++;
        total++; if (idx !== '0) $display("FAIL resync_idx got %0d want 0", idx); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL resync_overrun got %b want 0", overrun); else passed++;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (dout_valid !== 1'b0) $display("FAIL resync_one_word got %b want 0", dout_valid); else passed++;
        // sync alone abandons a partial frame
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (idx !== '0) $display("FAIL sync_only_idx got %0d want 0", idx); else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, i == 0, 1'b0);
        total++; if (idx !== IW'(5)) $display("FAIL areset_pre_idx got %0d want 5", idx); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (idx !== '0 || dout !== 8'h00 || dout_valid !== 1'b0 || overrun !== 1'b0)
            $display("FAIL areset_immediate got idx=%0d dout=%h vld=%b ovr=%b want 0/00/0/0", idx, dout, dout_valid, overrun);
        else passed++;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        total++; if (dout !== 8'h5A || dout_valid !== 1'b1) $display("FAIL areset_next got %h/%b want 5a/1", dout, dout_valid); else passed++;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

`ifdef DEMUX_DESER8_PARITY_EN
    task automatic test_parity();
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        total++; if (dout !== 8'h0F || dout_valid !== 1'b1) $display("FAIL par_good got %h/%b want 0f/1", dout, dout_valid); else passed++;
        total++; if (parity_err !== 1'b0) $display("FAIL par_good_err got %b want 0", parity_err); else passed++;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        total++; if (dout_valid !== 1'b0 || parity_err !== 1'b1) $display("FAIL par_bad got vld=%b err=%b want 0/1", dout_valid, parity_err); else passed++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (parity_err !== 1'b0 || overrun !== 1'b0) $display("FAIL par_pulse got err=%b ovr=%b want 0/0", parity_err, overrun); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_resync();
        test_async_reset();
`ifdef DEMUX_DESER8_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
